// File: rtl/cpu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------
// cpu_pkg : opcode, addressing-mode and state encodings plus ALU helper
// Rev 1.0
// ---------------------------------------------------------------------
package cpu_pkg;

  localparam int c_WORD_W = 16;

  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_LOAD   = 4'h1,
    OP_STORE  = 4'h2,
    OP_ADD    = 4'h3,
    OP_SUB    = 4'h4,
    OP_AND    = 4'h5,
    OP_OR     = 4'h6,
    OP_XOR    = 4'h7,
    OP_JMP    = 4'h8,
    OP_JZ     = 4'h9,
    OP_JN     = 4'hA,
    OP_OUT_LO = 4'hB,
    OP_OUT_HI = 4'hC,
    OP_IN     = 4'hD,
    OP_HALT   = 4'hE,
    OP_ILL    = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    MODE_NONE = 2'b00,
    MODE_IMM  = 2'b01,
    MODE_DIR  = 2'b10,
    MODE_ILL  = 2'b11
  } mode_e;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_FETCH      = 4'd1,
    S_FETCH_WAIT = 4'd2,
    S_EXEC       = 4'd3,
    S_OPER_WAIT  = 4'd4,
    S_DATA       = 4'd5,
    S_DATA_WAIT  = 4'd6,
    S_HALT       = 4'd7,
    S_TRAP       = 4'd8
  } state_e;

  // Accumulator update for the data-processing opcodes; others keep acc.
  function automatic logic [c_WORD_W-1:0] alu(input opcode_e op,
                                              input logic [c_WORD_W-1:0] a,
                                              input logic [c_WORD_W-1:0] b);
    case (op)
      OP_LOAD: alu = b;
      OP_ADD:  alu = a + b;
      OP_SUB:  alu = a - b;
      OP_AND:  alu = a & b;
      OP_OR:   alu = a | b;
      OP_XOR:  alu = a ^ b;
      default: alu = a;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/acc_cpu_if.sv
`default_nettype none
// ---------------------------------------------------------------------
// acc_cpu_if : word-addressed memory bus with start pulses and busy
// Rev 1.0
// ---------------------------------------------------------------------
interface acc_cpu_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [15:0]       mem_rdata;
  logic              mem_busy;

  modport master (output mem_addr, mem_wdata, mem_rd, mem_wr,
                  input  mem_rdata, mem_busy);
  modport slave  (input  mem_addr, mem_wdata, mem_rd, mem_wr,
                  output mem_rdata, mem_busy);
endinterface
`default_nettype wire

// File: rtl/acc_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------
// acc_decoder : opcode/mode split, legality and operand-needed flags
// Rev 1.0
// ---------------------------------------------------------------------
module acc_decoder
  import cpu_pkg::*;
(
  input  wire [5:0] field,
  output opcode_e   opcode,
  output mode_e     mode,
  output logic      legal,
  output logic      needs_oper
);

  always_comb begin
    opcode = opcode_e'(field[5:2]);
    mode   = mode_e'(field[1:0]);
    legal  = 1'b0;
    case (opcode)
      OP_NOP, OP_OUT_LO, OP_OUT_HI, OP_IN, OP_HALT:
        legal = (mode == MODE_NONE);
      OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
        legal = (mode == MODE_IMM) || (mode == MODE_DIR);
      OP_STORE:
        legal = (mode == MODE_DIR);
      OP_JMP, OP_JZ, OP_JN:
        legal = (mode == MODE_IMM);
      default:
        legal = 1'b0;
    endcase
    needs_oper = legal && (mode != MODE_NONE);
  end

endmodule
`default_nettype wire

// File: rtl/acc_cpu.sv
`default_nettype none
// ---------------------------------------------------------------------
// acc_cpu : multi-cycle 16-bit accumulator CPU on a busy-handshake bus
// Rev 1.0
// ---------------------------------------------------------------------
module acc_cpu
  import cpu_pkg::*;
#(
  parameter int               ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  wire        clk,
  input  wire        rst_n,
  input  wire        step,
  input  wire        run,
  output logic       busy,
  output logic       halt,
  output logic       trap,
  input  wire  [7:0] data_in,
  output logic [7:0] data_out,
  acc_cpu_if.master  mem
);

  state_e              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_addr;
  logic [c_WORD_W-1:0] r_acc;
  logic [c_WORD_W-1:0] r_wdata;
  logic [5:0]          r_inst;   // bits [9:0] carry no meaning, only the decode field is kept
  logic                r_rd;
  logic                r_wr;
  logic [7:0]          r_dout;

  logic [5:0]          w_dec_field;
  opcode_e             w_op;
  mode_e               w_mode;
  logic                w_legal;
  logic                w_needs_oper;
  logic [ADDR_W-1:0]   w_pc_inc1;
  logic [ADDR_W-1:0]   w_pc_inc2;
  logic [ADDR_W-1:0]   w_oper_addr;

  // Decoding the incoming word in FETCH_WAIT lets the operand read pulse during EXEC.
  assign w_dec_field = (r_state == S_FETCH_WAIT) ? mem.mem_rdata[15:10] : r_inst;
  assign w_pc_inc1   = r_pc + ADDR_W'(1);
  assign w_pc_inc2   = r_pc + ADDR_W'(2);
  assign w_oper_addr = ADDR_W'(mem.mem_rdata);

  acc_decoder u_dec (
    .field      (w_dec_field),
    .opcode     (w_op),
    .mode       (w_mode),
    .legal      (w_legal),
    .needs_oper (w_needs_oper)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_addr  <= '0;
      r_acc   <= '0;
      r_wdata <= '0;
      r_inst  <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_rd <= 1'b0;
      r_wr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (step || run) begin
            r_state <= S_FETCH;
            r_rd    <= 1'b1;
            r_addr  <= r_pc;
          end
        end
        S_FETCH: r_state <= S_FETCH_WAIT;
        S_FETCH_WAIT: begin
          if (!mem.mem_busy) begin
            r_inst  <= mem.mem_rdata[15:10];
            r_state <= S_EXEC;
            if (w_needs_oper) begin
              r_rd   <= 1'b1;
              r_addr <= w_pc_inc1;
            end
          end
        end
        S_EXEC: begin
          if (!w_legal) begin
            r_state <= S_TRAP;
          end else if (w_needs_oper) begin
            r_state <= S_OPER_WAIT;
          end else if (w_op == OP_HALT) begin
            r_state <= S_HALT;
          end else begin
            r_state <= S_IDLE;
            r_pc    <= w_pc_inc1;
            case (w_op)
              OP_OUT_LO: r_dout <= r_acc[7:0];
              OP_OUT_HI: r_dout <= r_acc[15:8];
              OP_IN:     r_acc  <= {8'h00, data_in};
              default:   ;
            endcase
          end
        end
        S_OPER_WAIT: begin
          if (!mem.mem_busy) begin
            if (w_mode == MODE_IMM) begin
              r_state <= S_IDLE;
              case (w_op)
                OP_JMP:  r_pc <= w_oper_addr;
                OP_JZ:   r_pc <= (r_acc == '0) ? w_oper_addr : w_pc_inc2;
                OP_JN:   r_pc <= r_acc[15] ? w_oper_addr : w_pc_inc2;
                default: begin
                  r_acc <= alu(w_op, r_acc, mem.mem_rdata);
                  r_pc  <= w_pc_inc2;
                end
              endcase
            end else begin
              r_state <= S_DATA;
              r_addr  <= w_oper_addr;
              if (w_op == OP_STORE) begin
                r_wr    <= 1'b1;
                r_wdata <= r_acc;
              end else begin
                r_rd <= 1'b1;
              end
            end
          end
        end
        S_DATA: r_state <= S_DATA_WAIT;
        S_DATA_WAIT: begin
          if (!mem.mem_busy) begin
            if (w_op != OP_STORE) r_acc <= alu(w_op, r_acc, mem.mem_rdata);
            r_pc    <= w_pc_inc2;
            r_state <= S_IDLE;
          end
        end
        default: ;  // HALT and TRAP hold until reset
      endcase
    end
  end

  assign busy          = (r_state != S_IDLE) && (r_state != S_HALT) && (r_state != S_TRAP);
  assign halt          = (r_state == S_HALT);
  assign trap          = (r_state == S_TRAP);
  assign data_out      = r_dout;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;
  assign mem.mem_rd    = r_rd;
  assign mem.mem_wr    = r_wr;

endmodule
`default_nettype wire

// File: tb/tb_acc_cpu.sv
`default_nettype none
// tb_acc_cpu : scoreboard bench; expected data_out bytes and store traffic
// are queued as programs are loaded and popped as the DUT produces them.
module tb_acc_cpu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, step, run, step8;
  logic [7:0] data_in;
  logic       busy, halt, trap, busy8, halt8, trap8;
  logic [7:0] data_out, data_out8;

  acc_cpu_if #(.ADDR_W(16)) bus ();
  acc_cpu_if #(.ADDR_W(8))  bus8 ();

  acc_cpu #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .step(step), .run(run),
    .busy(busy), .halt(halt), .trap(trap),
    .data_in(data_in), .data_out(data_out), .mem(bus)
  );

  acc_cpu #(.ADDR_W(8), .RESET_PC(8'hFF)) dut8 (
    .clk(clk), .rst_n(rst_n), .step(step8), .run(1'b0),
    .busy(busy8), .halt(halt8), .trap(trap8),
    .data_in(8'h00), .data_out(data_out8), .mem(bus8)
  );

  // Narrow instance sees an all-NOP zero-wait memory.
  assign bus8.mem_rdata = 16'h0000;
  assign bus8.mem_busy  = 1'b0;

  // Memory model: busy for 'lat' cycles after each start pulse.
  logic [15:0] mem [0:255];
  logic [15:0] rdata;
  int          cnt, lat;
  logic        ld_en;
  logic [7:0]  ld_a;
  logic [15:0] ld_d;

  always @(posedge clk) begin
    if (ld_en) mem[ld_a] <= ld_d;
    if (!rst_n) begin
      cnt <= 0;
    end else if (bus.mem_wr) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      cnt <= lat;
    end else if (bus.mem_rd) begin
      rdata <= mem[bus.mem_addr[7:0]];
      cnt   <= lat;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
    end
  end
  assign bus.mem_rdata = rdata;
  assign bus.mem_busy  = (cnt != 0);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [7:0]  exp_out_q [$];
  logic [31:0] exp_wr_q [$];
  logic [7:0]  prev_out = 8'h00;
  logic [7:0]  exp_byte;
  logic [31:0] exp_wr;
  int          rd_count = 0;
  int          wr_count = 0;

  always @(negedge clk) begin
    if (rst_n && data_out !== prev_out) begin
      if (exp_out_q.size() != 0) exp_byte = exp_out_q.pop_front();
      else                       exp_byte = prev_out;
      check("data_out", 32'(data_out), 32'(exp_byte));
    end
    prev_out = data_out;
    if (bus.mem_rd || bus.mem_wr) check("rd_wr_excl", 32'(bus.mem_rd & bus.mem_wr), 32'd0);
    if (bus.mem_rd) rd_count++;
    if (bus.mem_wr) begin
      wr_count++;
      if (exp_wr_q.size() != 0) begin
        exp_wr = exp_wr_q.pop_front();
        check("mem_write", {bus.mem_addr, bus.mem_wdata}, exp_wr);
      end else begin
        check("unexpected_write", 32'(exp_wr_q.size()), 32'd1);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; run = 1'b0; step = 1'b0; step8 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load(input logic [7:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_a = a; ld_d = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic run_until_stop(input int budget);
    int n = 0;
    run = 1'b1;
    while (!(halt || trap) && n < budget) begin
      @(negedge clk);
      n++;
    end
    run = 1'b0;
    check("stop_reached", 32'(halt | trap), 32'd1);
  endtask

  task automatic step_once(output int busy_cycles);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    busy_cycles = 0;
    while (busy && busy_cycles < 50) begin
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  int bc, rd0, wr0, n;

  initial begin
    rst_n = 1'b0; step = 1'b0; run = 1'b0; step8 = 1'b0; data_in = 8'h00;
    ld_en = 1'b0; ld_a = '0; ld_d = '0; lat = 0;

    // Reset state
    do_reset();
    check("rst_busy_halt_trap", {29'd0, busy, halt, trap}, 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_pc", 32'(dut.r_pc), 32'd0);
    check("rst_acc", 32'(dut.r_acc), 32'd0);
    check("rst_bus", {15'd0, bus.mem_rd, bus.mem_wr, bus.mem_wdata}, 32'd0);
    check("rst_pc8", 32'(dut8.r_pc), 32'h0FF);

    // 8-bit pc wraps from 0xFF to 0x00 over a NOP
    step8 = 1'b1;
    @(negedge clk);
    step8 = 1'b0;
    n = 0;
    while (busy8 && n < 50) begin n++; @(negedge clk); end
    check("pc8_wrap", 32'(dut8.r_pc), 32'h000);
    check("dut8_flags", {22'd0, busy8, halt8, trap8, data_out8}, 32'd0);

    // 3-cycle busy memory: LOAD #0x1234, OUT_LO, OUT_HI, NOP, HALT (HALT at word 5)
    lat = 3;
    load(8'h00, 16'h1400); load(8'h01, 16'h1234); load(8'h02, 16'hB000);
    load(8'h03, 16'hC000); load(8'h04, 16'h0000); load(8'h05, 16'hE000);
    exp_out_q.push_back(8'h34); exp_out_q.push_back(8'h12);
    run_until_stop(400);
    repeat (5) @(negedge clk);
    check("a_halt", {29'd0, halt, trap, busy}, 32'b100);
    check("a_pc", 32'(dut.r_pc), 32'd5);
    check("a_out_drained", 32'(exp_out_q.size()), 32'd0);

    // Arithmetic wrap and JN taken
    do_reset();
    lat = 1;
    load(8'h00, 16'h1400); load(8'h01, 16'hFFFF); load(8'h02, 16'h3400);
    load(8'h03, 16'h0002); load(8'h04, 16'hB000); load(8'h05, 16'hC000);
    load(8'h06, 16'h4400); load(8'h07, 16'h0002); load(8'h08, 16'hC000);
    load(8'h09, 16'hA400); load(8'h0A, 16'h0040); load(8'h40, 16'hE000);
    exp_out_q.push_back(8'h01); exp_out_q.push_back(8'h00); exp_out_q.push_back(8'hFF);
    run_until_stop(400);
    check("b_acc", 32'(dut.r_acc), 32'h0000FFFF);
    check("b_pc", 32'(dut.r_pc), 32'h40);
    check("b_out_drained", 32'(exp_out_q.size()), 32'd0);

    // Direct AND, STORE, JZ taken
    do_reset();
    lat = 2;
    load(8'h20, 16'h00F0); load(8'h21, 16'hBEEF);
    load(8'h00, 16'h1400); load(8'h01, 16'h0F0F); load(8'h02, 16'h5800);
    load(8'h03, 16'h0020); load(8'h04, 16'h2800); load(8'h05, 16'h0021);
    load(8'h06, 16'h9400); load(8'h07, 16'h0010); load(8'h10, 16'hE000);
    exp_wr_q.push_back({16'h0021, 16'h0000});
    run_until_stop(400);
    check("c_mem21", 32'(mem[8'h21]), 32'h0);
    check("c_pc", 32'(dut.r_pc), 32'h10);
    check("c_acc", 32'(dut.r_acc), 32'h0);
    check("c_wr_drained", 32'(exp_wr_q.size()), 32'd0);

    // Illegal opcode at word 3, then STORE immediate at word 3
    do_reset();
    lat = 0;
    load(8'h00, 16'h1400); load(8'h01, 16'h5555); load(8'h02, 16'h0000);
    load(8'h03, 16'hF000);
    run_until_stop(200);
    check("d1_flags", {29'd0, trap, busy, halt}, 32'b100);
    check("d1_pc", 32'(dut.r_pc), 32'd3);
    check("d1_acc", 32'(dut.r_acc), 32'h5555);
    run = 1'b1;
    repeat (6) @(negedge clk);
    run = 1'b0;
    check("d1_trap_sticky", {30'd0, trap, busy}, 32'b10);
    do_reset();
    load(8'h03, 16'h2400);
    run_until_stop(200);
    check("d2_flags", {29'd0, trap, busy, halt}, 32'b100);
    check("d2_pc", 32'(dut.r_pc), 32'd3);

    // Single step over NOP, then IN
    do_reset();
    lat = 0;
    load(8'h00, 16'h0000); load(8'h01, 16'hD000);
    rd0 = rd_count;
    step_once(bc);
    check("e_busy_cycles", 32'(bc), 32'd3);
    check("e_one_read", 32'(rd_count - rd0), 32'd1);
    check("e_pc", 32'(dut.r_pc), 32'd1);
    data_in = 8'hA5;
    step_once(bc);
    check("e_in_acc", 32'(dut.r_acc), 32'h00A5);
    check("e_in_pc", 32'(dut.r_pc), 32'd2);

    // Reset during DATA_WAIT of a STORE abandons the access
    do_reset();
    lat = 5;
    load(8'h00, 16'h2800); load(8'h01, 16'h0030);
    exp_wr_q.push_back({16'h0030, 16'h0000});
    run = 1'b1;
    n = 0;
    while (!bus.mem_wr && n < 100) begin n++; @(negedge clk); end
    check("f_write_seen", 32'(bus.mem_wr), 32'd1);
    repeat (2) @(negedge clk);
    check("f_in_data_wait", 32'(busy), 32'd1);
    rst_n = 1'b0; run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wr0 = wr_count;
    check("f_after_rst", {30'd0, busy, bus.mem_wr}, 32'd0);
    repeat (12) @(negedge clk);
    check("f_no_write", 32'(wr_count - wr0), 32'd0);
    check("f_pc", 32'(dut.r_pc), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
